// File: rtl/add_sub_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
package add_sub_pkg;

    // Width of the shared adder slice
    localparam int NIB_W = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_sub_seq_nibble_add.sv
// Combinational 4-bit adder slice with carry in/out, reused every nibble.
module nibble_add
    import add_sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    // One extra bit of headroom captures the carry out of the slice
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit add/subtract built on one 4-bit slice, LSB nibble first.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             zero,
    output logic             out_c
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               out_c_q, out_c_d;

    logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
    logic               nib_c;

    // Current nibble of each operand feeds the shared slice
    assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

    nibble_add u_nibble_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Handshake outputs follow the state directly
    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign s           = s_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign out_c       = out_c_q;

    // Next-state logic: latch command, walk nibbles, publish result, wait for consumer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        out_c_d = out_c_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    // Subtraction becomes a + ~b + 1, so the +1 rides in on the carry
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                p_d[idx_q*NIB_W +: NIB_W] = nib_s;
                carry_d = nib_c;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    s_d     = p_d;
                    out_c_d = nib_c;
                    zero_d  = (p_d == '0);
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (p_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            out_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            out_c_q <= out_c_d;
        end
    end

endmodule
